// File: rtl/hash_readout_ctrl.sv
// Captures the SHA-256 digest from dmem mailbox writes and sequences it, one word per dwell period,
// to the seven-segment display path; a push-button can step through the words manually.
module hash_readout_ctrl #(
    parameter logic [11:0] BASE_ADDR    = 12'hF00,
    parameter logic [11:0] DONE_ADDR    = 12'hF08,
    parameter int unsigned DWELL_CYCLES = 100000000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        step_btn,
    output logic        finished,
    output logic [31:0] hash_word,
    output logic [2:0]  word_idx,
    output logic [7:0]  valid_mask,
    output logic        err_incomplete
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {
        StCollect,
        StDisplay
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       words_q [8];
    logic [31:0]       words_d [8];
    logic [7:0]        mask_q, mask_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              sync1_q, sync2_q, edge_q;

    logic [11:0]       offs;
    logic              digest_wr;
    logic              mbox_wr;
    logic              restart;
    logic              done_wr;
    logic              step_pulse;

    // Offset into the digest region; any value >= 8 (including wrap below BASE_ADDR) is outside.
    assign offs       = address_dmem - BASE_ADDR;
    assign digest_wr  = wren && (offs[11:3] == 9'd0);
    assign mbox_wr    = wren && (address_dmem == DONE_ADDR);
    assign restart    = mbox_wr && (data == 32'd0);
    assign done_wr    = mbox_wr && (data != 32'd0);
    assign step_pulse = sync2_q & ~edge_q;

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (restart) begin
            state_d = StCollect;
            words_d = '{default: '0};
            mask_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    idx_d = '0;
                    cnt_d = '0;
                    if (digest_wr) begin
                        words_d[offs[2:0]] = data;
                        mask_d[offs[2:0]]  = 1'b1;
                    end
                    if (done_wr) begin
                        if (&mask_q) begin
                            state_d = StDisplay;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StDisplay: begin
                    // A button pulse coinciding with terminal count still advances only once.
                    if (step_pulse || (cnt_q == CntLast)) begin
                        cnt_d = '0;
                        idx_d = idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StCollect;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StCollect;
            words_q <= '{default: '0};
            mask_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign finished       = (state_q == StDisplay);
    assign hash_word      = words_q[idx_q];
    assign word_idx       = idx_q;
    assign valid_mask     = mask_q;
    assign err_incomplete = err_q;

endmodule
